regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 16x16 register file between up to four write requesters, using round-robin arbitration and a valid/ready handshake per requester. It drives the register file's write_en/write_addr/data_in directly and is the only block that does so. An optional clear sequencer sweeps every register to zero after reset or on command, because the register file's own reset only clears the currently addressed entry.

## Interface
- NREQ, 3, number of write requesters, legal range 2..4
- DATA_W, 16, data width; must match register file size
- ADDR_W, 4, address width; sweep depth is 2^ADDR_W
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*ADDR_W  packed; requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed; requester i at bits [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  one-hot or zero; combinational grant
- clear_req  in  1  single-cycle pulse requesting a full zero sweep
- busy  out  1  high while the clear sweep runs
- grant_id  out  2  index of the last accepted requester (registered)
- rf_write_en  out  1  to register file write_en (registered)
- rf_write_addr  out  ADDR_W  to register file write_addr (registered)
- rf_data_in  out  DATA_W  to register file data_in (registered)

## Operation
- States: CLEAR, ARB. busy = (state == CLEAR).
- Transfer on requester i: req_valid[i] && req_ready[i] in the same cycle.
- Requesters hold valid, addr and data stable until accepted. Valid is never withdrawn before acceptance.
- ARB:
  - req_ready[i] = 1 for exactly one valid requester: the first valid index at or after the pointer ptr, searching upward modulo NREQ.
  - If no requester is valid, all ready bits are 0.
  - The valid→ready path is combinational by design.
- Pointer update:
  - After a grant to i, ptr = (i+1) mod NREQ.
  - ptr does not move in cycles with no grant.
  - Reset value of ptr is 0.
- On a transfer, the next edge registers rf_write_en=1, rf_write_addr=req_addr[i], rf_data_in=req_data[i], grant_id=i.
- With no transfer, rf_write_en=0. rf_write_addr, rf_data_in and grant_id hold their previous values.
- Throughput: one write per cycle.
- CLEAR:
  - All req_ready are 0.
  - Counter cnt runs from 0 to 2^ADDR_W-1. Each edge registers rf_write_en=1, rf_write_addr=cnt, rf_data_in=0.
  - After the edge that issues address 2^ADDR_W-1, state becomes ARB and cnt resets to 0.
- clear_req in ARB (macro enabled):
  - All req_ready are forced to 0 that cycle, so no transfer occurs.
  - State becomes CLEAR at the next edge.
- clear_req in CLEAR is ignored; the sweep does not restart.
- Reset mid-operation: all state and outputs return to reset values immediately (asynchronous). Any in-flight write is dropped, and requesters re-present.
- Reset values:
  - rf_write_en=0, rf_write_addr=0, rf_data_in=0, grant_id=0, ptr=0, cnt=0.
  - State is CLEAR with the macro (busy=1), ARB without it (busy=0).

## Timing
- Acceptance at edge N puts the register file write on the bus during cycle N+1; it lands in the register file at edge N+1.
- Clear sweep:
  - The first sweep write is registered at the first edge after reset release, or at the edge after clear_req is sampled.
  - The sweep then occupies exactly 2^ADDR_W consecutive cycles of rf_write_en (16 at defaults).
  - req_ready can first assert in the cycle following the last sweep edge.
- busy is high from reset, or from the edge after clear_req, through the last sweep edge.

## Configuration
- REGFILE_ARB_CLEAR_EN defined:
  - CLEAR state, cnt and clear_req handling are present.
  - Reset enters CLEAR.
- REGFILE_ARB_CLEAR_EN undefined:
  - No CLEAR state and no cnt.
  - clear_req is ignored and busy is tied to 0.
  - Reset enters ARB directly.
  - Arbitration behaviour is otherwise identical.

## Test plan
- Reset release with macro, no requests -> rf_write_en high 16 cycles, addresses 0..15, data 0, busy high for those 16 cycles; the first req_ready is seen the next cycle.
- Single requester 1 valid, addr 5, data 0xBEEF, in ARB -> req_ready[1] same cycle; next cycle rf_write_en=1, addr 5, data 0xBEEF, grant_id=1.
- All three valid continuously with ptr=0 -> grant order 0,1,2,0,1,2; six writes in six consecutive cycles.
- Requesters 0 and 2 valid, ptr=1 -> 2 is granted first, then 0; ptr ends at 1.
- clear_req pulsed while requester 0 valid -> no ready that cycle; 16-cycle zero sweep; requester 0 is accepted in the first cycle after the sweep.
- reset_n asserted mid-sweep at address 7, then released -> outputs zero immediately; the sweep restarts at address 0. Without the macro, the bench checks busy=0 and the first grant in the cycle after reset release.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-requester bundle for regfile_write_arbiter: per-requester valid/addr/data
// (packed, requester i at slice i) and the combinational ready grant returned.
interface regfile_write_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register file write port. Define REGFILE_ARB_CLEAR_EN
// to add the zero-sweep sequencer that runs after reset and on clear_req.

// Per-requester slice of the one-hot AND-OR write mux.
module regfile_write_arbiter_lane #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr_term,
    output logic [DATA_W-1:0] data_term
);
    assign addr_term = sel ? addr : '0;
    assign data_term = sel ? data : '0;
endmodule

module regfile_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    regfile_write_arbiter_if.slave  req,
    input  logic                    clear_req,
    output logic                    busy,
    output logic [1:0]              grant_id,
    output logic                    rf_write_en,
    output logic [ADDR_W-1:0]       rf_write_addr,
    output logic [DATA_W-1:0]       rf_data_in
);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_ARB   = 1'b1;

    logic [1:0]                        ptr;
    logic [NREQ-1:0]                   gnt;
    logic [1:0]                        gnt_idx;
    logic [NREQ-1:0]                   ready;
    logic                              blocked;
    logic                              sweeping;
    logic                              xfer;
    logic [ADDR_W-1:0]                 sweep_addr;
    logic [NREQ-1:0][ADDR_W-1:0]       addr_term;
    logic [NREQ-1:0][DATA_W-1:0]       data_term;
    logic [ADDR_W-1:0]                 sel_addr;
    logic [DATA_W-1:0]                 sel_data;

`ifdef REGFILE_ARB_CLEAR_EN
    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            if (cnt == {ADDR_W{1'b1}}) begin
                state <= ST_ARB;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (clear_req) begin
            state <= ST_CLEAR;
        end
    end

    assign sweeping   = (state == ST_CLEAR);
    assign sweep_addr = cnt;
    // A clear request steals its own cycle so no write races the sweep.
    assign blocked    = sweeping || clear_req;
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req;
    assign sweeping   = 1'b0;
    assign sweep_addr = '0;
    assign blocked    = 1'b0;
`endif

    assign busy = sweeping;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        logic       found;
        logic [2:0] j;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = {1'b0, ptr} + 3'(k);
            if (j >= 3'(NREQ)) j = j - 3'(NREQ);
            if (!found && req.req_valid[j[1:0]]) begin
                found         = 1'b1;
                gnt[j[1:0]]   = 1'b1;
                gnt_idx       = j[1:0];
            end
        end
    end

    assign ready         = blocked ? '0 : gnt;
    assign req.req_ready = ready;
    assign xfer          = |ready;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        regfile_write_arbiter_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
            .sel       (ready[i]),
            .addr      (req.req_addr[i*ADDR_W +: ADDR_W]),
            .data      (req.req_data[i*DATA_W +: DATA_W]),
            .addr_term (addr_term[i]),
            .data_term (data_term[i])
        );
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_addr = sel_addr | addr_term[i];
            sel_data = sel_data | data_term[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_data_in    <= '0;
            grant_id      <= '0;
            ptr           <= '0;
        end else if (sweeping) begin
            rf_write_en   <= 1'b1;
            rf_write_addr <= sweep_addr;
            rf_data_in    <= '0;
        end else if (xfer) begin
            rf_write_en   <= 1'b1;
            rf_write_addr <= sel_addr;
            rf_data_in    <= sel_data;
            grant_id      <= gnt_idx;
            ptr           <= (gnt_idx == 2'(NREQ-1)) ? 2'd0 : gnt_idx + 2'd1;
        end else begin
            rf_write_en   <= 1'b0;
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(ready));
    a_ready_valid: assert property (@(posedge clk) disable iff (!reset_n)
        (ready & ~req.req_valid) == '0);
    a_ready_idle: assert property (@(posedge clk) disable iff (!reset_n)
        busy |-> (ready == '0));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table of grant patterns with a write
// scoreboard, plus hand sequences for the clear sweep and mid-operation reset.
module tb_regfile_write_arbiter;
    localparam int NREQ = 3, DATA_W = 16, ADDR_W = 4;

    logic clk, reset_n, clear_req;
    logic busy, rf_write_en;
    logic [1:0] grant_id;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_data_in;

    regfile_write_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) rif ();

    regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .req(rif.slave), .clear_req(clear_req),
        .busy(busy), .grant_id(grant_id), .rf_write_en(rf_write_en),
        .rf_write_addr(rf_write_addr), .rf_data_in(rf_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]        valid;
        logic [NREQ*ADDR_W-1:0] addr;
        logic [NREQ*DATA_W-1:0] data;
        logic [NREQ-1:0]        exp_ready;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        id;
    } wr_t;

    vec_t tbl[18];
    wr_t  sb[$];
    int   n_vec = 0, n_err = 0;
    logic [ADDR_W-1:0] held_addr;
    logic [DATA_W-1:0] held_data;
    logic [1:0]        held_id;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ*ADDR_W-1:0] mk_a(input int s);
        logic [NREQ*ADDR_W-1:0] a;
        for (int r = 0; r < NREQ; r++) a[r*ADDR_W +: ADDR_W] = 4'((s*3 + r*5) % 16);
        return a;
    endfunction

    function automatic logic [NREQ*DATA_W-1:0] mk_d(input int s);
        logic [NREQ*DATA_W-1:0] d;
        for (int r = 0; r < NREQ; r++) d[r*DATA_W +: DATA_W] = 16'(32'h5A00 ^ (s*32'h0111) ^ (r << 12));
        return d;
    endfunction

    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*ADDR_W-1:0] a,
                         input logic [NREQ*DATA_W-1:0] d, input logic clr);
        rif.req_valid = v;
        rif.req_addr  = a;
        rif.req_data  = d;
        clear_req     = clr;
    endtask

    // Entered and left at posedge+1; one cycle of stimulus and checks.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*ADDR_W-1:0] a,
                        input logic [NREQ*DATA_W-1:0] d, input logic clr,
                        input logic [NREQ-1:0] exp_rdy, input logic exp_busy);
        wr_t w;
        logic pushed;
        drive(v, a, d, clr);
        #4;
        chk("req_ready", 64'(rif.req_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(exp_busy));
        pushed = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            if (exp_rdy[r]) begin
                w.addr = a[r*ADDR_W +: ADDR_W];
                w.data = d[r*DATA_W +: DATA_W];
                w.id   = 2'(r);
                sb.push_back(w);
                pushed = 1'b1;
            end
        end
        @(posedge clk); #1;
        clear_req = 1'b0;
        if (pushed) begin
            w = sb.pop_front();
            chk("wr_en", 64'(rf_write_en), 64'd1);
            chk("wr_addr", 64'(rf_write_addr), 64'(w.addr));
            chk("wr_data", 64'(rf_data_in), 64'(w.data));
            chk("grant_id", 64'(grant_id), 64'(w.id));
            held_addr = w.addr; held_data = w.data; held_id = w.id;
        end else begin
            chk("idle_en", 64'(rf_write_en), 64'd0);
            chk("hold_addr_data_id", {44'd0, rf_write_addr, rf_data_in},
                {44'd0, held_addr, held_data});
            chk("hold_id", 64'(grant_id), 64'(held_id));
        end
    endtask

    task automatic sweep(input int stop_after, input logic [NREQ-1:0] v,
                         input logic [NREQ*ADDR_W-1:0] a, input logic [NREQ*DATA_W-1:0] d);
        drive(v, a, d, 1'b0);
        for (int k = 0; k < (1 << ADDR_W); k++) begin
            #4;
            chk("sweep_ready", 64'(rif.req_ready), 64'd0);
            chk("sweep_busy", 64'(busy), 64'd1);
            @(posedge clk); #1;
            chk("sweep_en", 64'(rf_write_en), 64'd1);
            chk("sweep_addr", 64'(rf_write_addr), 64'(k));
            chk("sweep_data", 64'(rf_data_in), 64'd0);
            chk("sweep_id", 64'(grant_id), 64'(held_id));
            held_addr = 4'(k); held_data = '0;
            if (k == stop_after) return;
        end
    endtask

    task automatic check_reset(input logic exp_busy);
        chk("rst_en", 64'(rf_write_en), 64'd0);
        chk("rst_addr", 64'(rf_write_addr), 64'd0);
        chk("rst_data", 64'(rf_data_in), 64'd0);
        chk("rst_id", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'(exp_busy));
        held_addr = '0; held_data = '0; held_id = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cl;
`ifdef REGFILE_ARB_CLEAR_EN
        cl = 1'b1;
`else
        cl = 1'b0;
`endif
        tbl[0]  = '{3'b000, mk_a(1),  mk_d(1),  3'b000};
        tbl[1]  = '{3'b010, mk_a(2),  mk_d(2),  3'b010};
        tbl[1].addr[7:4]   = 4'd5;
        tbl[1].data[31:16] = 16'hBEEF;
        tbl[2]  = '{3'b000, mk_a(3),  mk_d(3),  3'b000};
        tbl[3]  = '{3'b100, mk_a(4),  mk_d(4),  3'b100};
        tbl[4]  = '{3'b111, mk_a(5),  mk_d(5),  3'b001};
        tbl[5]  = '{3'b111, mk_a(6),  mk_d(6),  3'b010};
        tbl[6]  = '{3'b111, mk_a(7),  mk_d(7),  3'b100};
        tbl[7]  = '{3'b111, mk_a(8),  mk_d(8),  3'b001};
        tbl[8]  = '{3'b111, mk_a(9),  mk_d(9),  3'b010};
        tbl[9]  = '{3'b111, mk_a(10), mk_d(10), 3'b100};
        tbl[10] = '{3'b001, mk_a(11), mk_d(11), 3'b001};
        tbl[11] = '{3'b101, mk_a(12), mk_d(12), 3'b100};
        tbl[12] = '{3'b001, mk_a(13), mk_d(13), 3'b001};
        tbl[13] = '{3'b011, mk_a(14), mk_d(14), 3'b010};
        tbl[14] = '{3'b011, mk_a(15), mk_d(15), 3'b001};
        tbl[15] = '{3'b110, mk_a(16), mk_d(16), 3'b010};
        tbl[16] = '{3'b110, mk_a(17), mk_d(17), 3'b100};
        tbl[17] = '{3'b110, mk_a(18), mk_d(18), 3'b010};

        reset_n = 1'b0;
        drive(3'b000, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_reset(cl);
        chk("rst_ready", 64'(rif.req_ready), 64'd0);
        reset_n = 1'b1;

`ifdef REGFILE_ARB_CLEAR_EN
        sweep(99, 3'b001, mk_a(30), mk_d(30));
`endif
        step(3'b001, mk_a(30), mk_d(30), 1'b0, 3'b001, 1'b0);

        for (int i = 0; i < 18; i++)
            step(tbl[i].valid, tbl[i].addr, tbl[i].data, 1'b0, tbl[i].exp_ready, 1'b0);

`ifdef REGFILE_ARB_CLEAR_EN
        step(3'b001, mk_a(40), mk_d(40), 1'b1, 3'b000, 1'b0);
        sweep(99, 3'b001, mk_a(40), mk_d(40));
        step(3'b001, mk_a(40), mk_d(40), 1'b0, 3'b001, 1'b0);
        step(3'b000, mk_a(41), mk_d(41), 1'b1, 3'b000, 1'b0);
        sweep(7, 3'b000, mk_a(41), mk_d(41));
        #1 reset_n = 1'b0;
        #1;
        check_reset(1'b1);
        chk("rst_mid_ready", 64'(rif.req_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        sweep(99, 3'b001, mk_a(42), mk_d(42));
        step(3'b001, mk_a(42), mk_d(42), 1'b0, 3'b001, 1'b0);
`else
        step(3'b001, mk_a(40), mk_d(40), 1'b1, 3'b001, 1'b0);
        step(3'b010, mk_a(41), mk_d(41), 1'b0, 3'b010, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check_reset(1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(3'b010, mk_a(42), mk_d(42), 1'b0, 3'b010, 1'b0);
`endif
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
